// File: rtl/score_keeper.sv
// Weighted, combo-scaled score accumulator with one-point-per-ROLL_DIV BCD roll-up,
// cross-game high score and active-low 7-segment drive of the displayed score.
module score_keeper #(
    parameter int DIGIT_AMOUNT   = 4,
    parameter int EVENT_CHANNELS = 3,
    parameter int WEIGHT_W       = 4,
    parameter int PEND_W         = 14,
    parameter int COMBO_WINDOW   = 64,
    parameter int COMBO_MAX      = 4,
    parameter int ROLL_DIV       = 1
) (
    input  logic                                     clk,
    input  logic                                     resetN,
    input  logic [EVENT_CHANNELS-1:0]                event_pulse,
    input  logic [EVENT_CHANNELS-1:0][WEIGHT_W-1:0]  event_weight,
    input  logic [2:0]                               stage_num,
    input  logic                                     game_over,
    input  logic                                     new_game,
    output logic [DIGIT_AMOUNT-1:0][3:0]             score_bcd,
    output logic [DIGIT_AMOUNT-1:0][3:0]             high_bcd,
    output logic [DIGIT_AMOUNT-1:0][6:0]             ss,
    output logic [$clog2(COMBO_MAX+1)-1:0]           combo,
    output logic                                     busy,
    output logic                                     saturated
);

    localparam int BASE_W   = WEIGHT_W + $clog2(EVENT_CHANNELS + 1);
    localparam int CMB_W    = $clog2(COMBO_MAX + 1);
    localparam int AMT_W    = BASE_W + 3 + CMB_W;
    localparam int SUM_W    = ((AMT_W > PEND_W) ? AMT_W : PEND_W) + 1;
    localparam int TMR_W    = $clog2(COMBO_WINDOW + 1);
    localparam int DIV_W    = (ROLL_DIV > 1) ? $clog2(ROLL_DIV) : 1;
    localparam int PEND_MAX = (2 ** PEND_W) - 1;

    localparam logic [CMB_W-1:0] COMBO_ONE = CMB_W'(1);
    localparam logic [CMB_W-1:0] COMBO_CAP = CMB_W'(COMBO_MAX);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(ROLL_DIV - 1);

    typedef logic [DIGIT_AMOUNT-1:0][3:0] bcd_t;
    typedef enum logic {S_IDLE, S_ROLL} state_t;

    state_t              r_state;
    state_t              w_state_next;
    bcd_t                r_score;
    bcd_t                r_high;
    logic [PEND_W-1:0]   r_pending;
    logic [CMB_W-1:0]    r_combo;
    logic [TMR_W-1:0]    r_timer;
    logic [DIV_W-1:0]    r_div;
    logic                r_saturated;

    logic [BASE_W-1:0]   w_base;
    logic [2:0]          w_stage;
    logic [CMB_W-1:0]    w_combo_next;
    logic [AMT_W-1:0]    w_amount;
    logic                w_intake;
    logic [SUM_W-1:0]    w_sum;
    logic [PEND_W-1:0]   w_pend_next;
    logic                w_all9;
    logic                w_tick;
    logic                w_step;
    logic                w_sat_hit;
    logic                w_busy;

    function automatic bcd_t bcd_inc(input bcd_t v);
        logic carry;
        carry   = 1'b1;
        bcd_inc = v;
        for (int i = 0; i < DIGIT_AMOUNT; i++) begin
            if (carry) begin
                if (v[i] == 4'd9) begin
                    bcd_inc[i] = 4'd0;
                end else begin
                    bcd_inc[i] = v[i] + 4'd1;
                    carry      = 1'b0;
                end
            end
        end
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    // NOTE: combinational blocks use blocking '=' and assign every output a default
    // first, so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_base = '0;
        for (int i = 0; i < EVENT_CHANNELS; i++) begin
            if (event_pulse[i]) begin
                w_base = w_base + BASE_W'(event_weight[i]);
            end
        end
    end

    assign w_stage  = (stage_num == 3'd0) ? 3'd1 : stage_num;
    assign w_intake = !game_over && !new_game && !r_saturated && (w_base != '0);

    // A new event inside the window escalates the combo, otherwise it restarts at 1.
    always_comb begin
        w_combo_next = COMBO_ONE;
        if (r_timer != '0) begin
            w_combo_next = (r_combo >= COMBO_CAP) ? COMBO_CAP : r_combo + COMBO_ONE;
        end
    end

    assign w_amount = AMT_W'(w_base) * AMT_W'(w_stage) * AMT_W'(w_combo_next);

    always_comb begin
        w_all9 = 1'b1;
        for (int i = 0; i < DIGIT_AMOUNT; i++) begin
            if (r_score[i] != 4'd9) begin
                w_all9 = 1'b0;
            end
        end
    end

    // Intake and a roll step in the same clock combine; a saturation hit drops everything.
    always_comb begin
        w_sum = SUM_W'(r_pending);
        if (w_intake) begin
            w_sum = w_sum + SUM_W'(w_amount);
        end
        if (w_step) begin
            w_sum = w_sum - SUM_W'(1);
        end
        if (new_game || w_sat_hit) begin
            w_pend_next = '0;
        end else if (w_sum > SUM_W'(PEND_MAX)) begin
            w_pend_next = PEND_W'(PEND_MAX);
        end else begin
            w_pend_next = w_sum[PEND_W-1:0];
        end
    end

    // Roll-up FSM: state register.
    // NOTE: sequential blocks use non-blocking '<=' so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Roll-up FSM: next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (!new_game && (r_pending != '0)) w_state_next = S_ROLL;
            S_ROLL: if (new_game || (w_pend_next == '0)) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Roll-up FSM: outputs.
    always_comb begin
        w_busy    = (r_state == S_ROLL) || (r_pending != '0);
        w_tick    = (r_state == S_ROLL) && (r_div == DIV_LAST) && (r_pending != '0);
        w_step    = w_tick && !w_all9;
        w_sat_hit = w_tick && w_all9;
    end

    // NOTE: every register here is a flop with a defined reset value; there is no
    // memory array, so the asynchronous reset covers the entire state.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_div <= '0;
        end else if (new_game || (r_state != S_ROLL) || (r_div == DIV_LAST)) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_pending   <= '0;
            r_score     <= '0;
            r_saturated <= 1'b0;
        end else begin
            r_pending <= w_pend_next;
            if (new_game) begin
                r_score     <= '0;
                r_saturated <= 1'b0;
            end else if (w_step) begin
                r_score <= bcd_inc(r_score);
            end else if (w_sat_hit) begin
                r_saturated <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_combo <= COMBO_ONE;
            r_timer <= '0;
        end else if (new_game) begin
            r_combo <= COMBO_ONE;
            r_timer <= '0;
        end else if (w_intake) begin
            r_combo <= w_combo_next;
            r_timer <= TMR_W'(COMBO_WINDOW);
        end else if (r_timer != '0) begin
            r_timer <= game_over ? '0 : r_timer - TMR_W'(1);
        end else begin
            r_combo <= COMBO_ONE;
        end
    end

    // Valid BCD orders the same as binary, so a whole-vector compare is MSD-first.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_high <= '0;
        end else if (game_over && !w_busy && (r_score > r_high)) begin
            r_high <= r_score;
        end
    end

    always_comb begin
        ss = '0;
        for (int i = 0; i < DIGIT_AMOUNT; i++) begin
            ss[i] = seg7(r_score[i]);
        end
    end

    assign score_bcd = r_score;
    assign high_bcd  = r_high;
    assign combo     = r_combo;
    assign busy      = w_busy;
    assign saturated = r_saturated;

endmodule
